// File: rtl/window_pkg.sv
// Shared types and constants for the window scan sequencer.
package window_pkg;

   localparam int WIN_DIM = 16;
   localparam int COORD_W = 7;

   typedef logic [COORD_W-1:0] coord_t;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ISSUE   = 3'd1,
      S_WAIT    = 3'd2,
      S_PRESENT = 3'd3,
      S_ADVANCE = 3'd4,
      S_FINISH  = 3'd5
   } scan_state_t;

endpackage

// File: rtl/scan_counter.sv
// 2-D origin counter: columns run fastest, rows advance on column wrap.
// Also keeps the linear window index presented to the NCC stage.
module scan_counter #(
   parameter int GRID_ROWS = 20,
   parameter int GRID_COLS = 20,
   parameter int IDX_W     = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clear,
   input  logic             i_step,
   output logic [IDX_W-1:0] o_index,
   output logic             o_last,
   output logic             o_col_wrap
);

   localparam int RW = (GRID_ROWS > 1) ? $clog2(GRID_ROWS) : 1;
   localparam int CW = (GRID_COLS > 1) ? $clog2(GRID_COLS) : 1;

   logic [RW-1:0]    r_r_cnt;
   logic [CW-1:0]    r_c_cnt;
   logic [IDX_W-1:0] r_index;
   logic             w_row_end;

   assign w_row_end  = (r_r_cnt == RW'(GRID_ROWS - 1));
   assign o_col_wrap = (r_c_cnt == CW'(GRID_COLS - 1));
   assign o_last     = w_row_end && o_col_wrap;
   assign o_index    = r_index;

   // Clear on accepted start, step column/row/index on each advance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_r_cnt <= '0;
         r_c_cnt <= '0;
         r_index <= '0;
      end else if (i_clear) begin
         r_r_cnt <= '0;
         r_c_cnt <= '0;
         r_index <= '0;
      end else if (i_step) begin
         r_index <= r_index + IDX_W'(1);
         if (o_col_wrap) begin
            r_c_cnt <= '0;
            r_r_cnt <= w_row_end ? '0 : r_r_cnt + RW'(1);
         end else begin
            r_c_cnt <= r_c_cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/window_scan_ctrl.sv
// Window fetch sequencer: sweeps the origin grid, fetches each window via
// window_handler, hands it to the NCC stage and flags stalled fetches.
module window_scan_ctrl
   import window_pkg::*;
#(
   parameter int GRID_ROWS = 20,
   parameter int GRID_COLS = 20,
   parameter int ROW_STEP  = 1,
   parameter int COL_STEP  = 1,
   parameter int IDX_W     = 12,
   parameter int TIMEOUT   = 4096
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [6:0]       row_base,
   input  logic [6:0]       col_base,
   output logic             win_en,
   output logic [6:0]       win_row,
   output logic [6:0]       win_col,
   input  logic             win_done,
   output logic             win_valid,
   input  logic             ncc_ready,
   output logic [IDX_W-1:0] win_index,
   output logic             busy,
   output logic             set_done,
   output logic             timeout_err
);

   localparam int WD_W = $clog2(TIMEOUT + 1);

   scan_state_t      r_state;
   coord_t           r_col_base;
   coord_t           r_win_row;
   coord_t           r_win_col;
   logic [WD_W-1:0]  r_wdog;
   logic             r_win_en;
   logic             r_win_valid;
   logic             r_busy;
   logic             r_set_done;
   logic             r_timeout_err;

   logic             w_clear;
   logic             w_step;
   logic             w_last;
   logic             w_col_wrap;
   logic [IDX_W-1:0] w_index;

   // A sweep starts only from IDLE and only when abort is not also asserted.
   assign w_clear = (r_state == S_IDLE) && start && !abort;
   assign w_step  = (r_state == S_ADVANCE) && !w_last && !abort;

   scan_counter #(
      .GRID_ROWS (GRID_ROWS),
      .GRID_COLS (GRID_COLS),
      .IDX_W     (IDX_W)
   ) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .i_clear    (w_clear),
      .i_step     (w_step),
      .o_index    (w_index),
      .o_last     (w_last),
      .o_col_wrap (w_col_wrap)
   );

   assign win_en      = r_win_en;
   assign win_row     = r_win_row;
   assign win_col     = r_win_col;
   assign win_valid   = r_win_valid;
   assign win_index   = w_index;
   assign busy        = r_busy;
   assign set_done    = r_set_done;
   assign timeout_err = r_timeout_err;

   // Sequencer FSM; outputs are registered on entry to the state that owns them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_col_base    <= '0;
         r_win_row     <= '0;
         r_win_col     <= '0;
         r_wdog        <= '0;
         r_win_en      <= 1'b0;
         r_win_valid   <= 1'b0;
         r_busy        <= 1'b0;
         r_set_done    <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         r_win_en   <= 1'b0;
         r_set_done <= 1'b0;
         if (abort) begin
            r_state     <= S_IDLE;
            r_win_valid <= 1'b0;
            r_busy      <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (start) begin
                     r_col_base    <= col_base;
                     r_win_row     <= row_base;
                     r_win_col     <= col_base;
                     r_timeout_err <= 1'b0;
                     r_busy        <= 1'b1;
                     r_win_en      <= 1'b1;
                     r_state       <= S_ISSUE;
                  end
               end
               S_ISSUE: begin
                  r_wdog  <= '0;
                  r_state <= S_WAIT;
               end
               S_WAIT: begin
                  if (win_done) begin
                     r_win_valid <= 1'b1;
                     r_state     <= S_PRESENT;
                  end else if (r_wdog == WD_W'(TIMEOUT - 1)) begin
                     r_timeout_err <= 1'b1;
                     r_state       <= S_FINISH;
                  end else begin
                     r_wdog <= r_wdog + WD_W'(1);
                  end
               end
               S_PRESENT: begin
                  if (ncc_ready) begin
                     r_win_valid <= 1'b0;
                     r_state     <= S_ADVANCE;
                  end
               end
               S_ADVANCE: begin
                  if (w_last) begin
                     r_set_done <= 1'b1;
                     r_state    <= S_FINISH;
                  end else begin
                     if (w_col_wrap) begin
                        r_win_col <= r_col_base;
                        r_win_row <= r_win_row + COORD_W'(ROW_STEP);
                     end else begin
                        r_win_col <= r_win_col + COORD_W'(COL_STEP);
                     end
                     r_win_en <= 1'b1;
                     r_state  <= S_ISSUE;
                  end
               end
               S_FINISH: begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
               default: begin
                  r_win_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Directed bench for window_scan_ctrl: two instances (2x3 unit step, 2x2 step 2),
// each with a window_handler model that answers 5 cycles after win_en.
module tb_window_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst, abort, ncc_ready, start1, start2;
   logic        done1 = 1'b0;
   logic        done2 = 1'b0;
   logic [6:0]  row_base, col_base;
   logic        en1, valid1, busy1, sd1, terr1;
   logic        en2, valid2, busy2, sd2, terr2;
   logic [6:0]  row1, col1, row2, col2;
   logic [11:0] idx1, idx2;
   int          n_checks = 0;
   int          n_fail = 0;
   int          n_en1 = 0;
   int          n_sd1 = 0;
   int          hcnt1 = 0;
   int          hcnt2 = 0;
   bit          hang1 = 1'b0;
   int          en_base, sd_base;

   always #5 clk = ~clk;

   window_scan_ctrl #(.GRID_ROWS(2), .GRID_COLS(3), .ROW_STEP(1), .COL_STEP(1),
                      .IDX_W(12), .TIMEOUT(16)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .abort(abort),
      .row_base(row_base), .col_base(col_base),
      .win_en(en1), .win_row(row1), .win_col(col1), .win_done(done1),
      .win_valid(valid1), .ncc_ready(ncc_ready), .win_index(idx1),
      .busy(busy1), .set_done(sd1), .timeout_err(terr1));

   window_scan_ctrl #(.GRID_ROWS(2), .GRID_COLS(2), .ROW_STEP(2), .COL_STEP(2),
                      .IDX_W(12), .TIMEOUT(16)) u_dut2 (
      .clk(clk), .rst(rst), .start(start2), .abort(1'b0),
      .row_base(row_base), .col_base(col_base),
      .win_en(en2), .win_row(row2), .win_col(col2), .win_done(done2),
      .win_valid(valid2), .ncc_ready(1'b1), .win_index(idx2),
      .busy(busy2), .set_done(sd2), .timeout_err(terr2));

   // Handler model 1: done pulse 5 cycles after win_en unless hung.
   always @(negedge clk) begin
      if (en1) begin hcnt1 = 5; done1 = 1'b0; end
      else if (hcnt1 != 0) begin hcnt1 = hcnt1 - 1; done1 = (hcnt1 == 0) && !hang1; end
      else done1 = 1'b0;
   end

   // Handler model 2: done pulse 5 cycles after win_en.
   always @(negedge clk) begin
      if (en2) begin hcnt2 = 5; done2 = 1'b0; end
      else if (hcnt2 != 0) begin hcnt2 = hcnt2 - 1; done2 = (hcnt2 == 0); end
      else done2 = 1'b0;
   end

   // Pulse counters for instance 1, sampled on the active edge.
   always @(posedge clk) begin
      if (en1) n_en1 = n_en1 + 1;
      if (sd1) n_sd1 = n_sd1 + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_for(input int sel, input int budget, input string tag);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < budget && !hit; i++) begin
         case (sel)
            0: hit = en1;
            1: hit = valid1;
            2: hit = sd1;
            3: hit = en2;
            4: hit = sd2;
            default: hit = 1'b0;
         endcase
         if (!hit) @(negedge clk);
      end
      check(tag, 32'(hit), 32'd1);
   endtask

   // Full 2x3 sweep on instance 1 from (0,0); optional 10-cycle stall at one index.
   task automatic run_sweep1(input int stall_at);
      int e0;
      start1 = 1'b1; @(negedge clk); start1 = 1'b0;
      en_base = n_en1; sd_base = n_sd1;
      check("sw_issue", {en1, busy1}, 2'b11);
      for (int w = 0; w < 6; w++) begin
         wait_for(0, 40, "sw_en_seen");
         check("sw_origin", {idx1, row1, col1}, {12'(w), 7'(w / 3), 7'(w % 3)});
         if (w == stall_at) ncc_ready = 1'b0;
         wait_for(1, 40, "sw_valid_seen");
         check("sw_present", {idx1, row1, col1}, {12'(w), 7'(w / 3), 7'(w % 3)});
         if (w == stall_at) begin
            e0 = n_en1;
            for (int i = 0; i < 10; i++) begin
               check("stall_hold", {valid1, idx1, row1, col1}, {1'b1, 12'd2, 7'd0, 7'd2});
               @(negedge clk);
            end
            ncc_ready = 1'b1;
            @(negedge clk);
            check("stall_release", 32'(valid1), 32'd0);
            check("stall_no_en", n_en1 - e0, 32'd0);
         end else begin
            @(negedge clk);
         end
      end
      wait_for(2, 10, "sw_set_done_seen");
      check("sw_busy_at_done", 32'(busy1), 32'd1);
      @(negedge clk);
      check("sw_idle_after", {busy1, sd1, valid1}, 3'b000);
      check("sw_en_count", n_en1 - en_base, 32'd6);
      check("sw_sd_count", n_sd1 - sd_base, 32'd1);
   endtask

   initial begin
      rst = 1'b1; abort = 1'b0; ncc_ready = 1'b1; start1 = 1'b0; start2 = 1'b0;
      row_base = 7'd0; col_base = 7'd0;
      repeat (2) @(negedge clk);
      check("reset_dut1", {en1, valid1, busy1, sd1, terr1, row1, col1, idx1}, 32'd0);
      check("reset_dut2", {en2, valid2, busy2, sd2, terr2, row2, col2, idx2}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Plain sweep, then sweep with a stall at index 2.
      run_sweep1(-1);
      run_sweep1(2);

      // Stepped origins on instance 2.
      row_base = 7'd4; col_base = 7'd8;
      start2 = 1'b1; @(negedge clk); start2 = 1'b0;
      for (int w = 0; w < 4; w++) begin
         wait_for(3, 40, "step_en_seen");
         check("step_origin", {idx2, row2, col2},
               {12'(w), 7'(4 + 2 * (w / 2)), 7'(8 + 2 * (w % 2))});
         @(negedge clk);
      end
      wait_for(4, 40, "step_set_done_seen");

      // Watchdog expiry on instance 1.
      row_base = 7'd0; col_base = 7'd0; hang1 = 1'b1;
      sd_base = n_sd1;
      start1 = 1'b1; @(negedge clk); start1 = 1'b0;
      check("to_issue", 32'(en1), 32'd1);
      repeat (16) @(negedge clk);
      check("to_wait16", {terr1, busy1}, 2'b01);
      @(negedge clk);
      check("to_finish", {terr1, sd1, busy1}, 3'b101);
      @(negedge clk);
      check("to_idle", {terr1, sd1, busy1}, 3'b100);
      check("to_no_set_done", n_sd1 - sd_base, 32'd0);
      abort = 1'b1; @(negedge clk); abort = 1'b0;
      check("abort_keeps_err", 32'(terr1), 32'd1);
      start1 = 1'b1; abort = 1'b1; @(negedge clk); start1 = 1'b0; abort = 1'b0;
      check("start_abort_idle", {busy1, en1, terr1}, 3'b001);
      @(negedge clk);
      check("start_abort_stay", {busy1, en1, terr1}, 3'b001);
      hang1 = 1'b0;
      start1 = 1'b1; @(negedge clk); start1 = 1'b0;
      check("restart_clears_err", {en1, terr1, busy1}, 3'b101);

      // Start while busy is ignored; abort during PRESENT of index 3.
      for (int w = 0; w < 4; w++) begin
         wait_for(0, 40, "ab_en_seen");
         if (w == 1) begin
            start1 = 1'b1; @(negedge clk); start1 = 1'b0;
            check("start_while_busy", {en1, busy1, idx1}, {1'b0, 1'b1, 12'd1});
         end
         wait_for(1, 40, "ab_valid_seen");
         if (w < 3) @(negedge clk);
      end
      check("ab_present3", {valid1, idx1}, {1'b1, 12'd3});
      abort = 1'b1; @(negedge clk); abort = 1'b0;
      check("abort_idle", {valid1, en1, busy1, terr1}, 4'b0000);
      en_base = n_en1;
      repeat (4) @(negedge clk);
      check("abort_no_en", n_en1 - en_base, 32'd0);

      // Restart from new bases, then async reset mid-WAIT.
      row_base = 7'd3; col_base = 7'd5;
      start1 = 1'b1; @(negedge clk); start1 = 1'b0;
      check("restart_origin", {en1, idx1, row1, col1}, {1'b1, 12'd0, 7'd3, 7'd5});
      wait_for(1, 40, "rs_valid_seen");
      @(negedge clk);
      wait_for(0, 40, "rs_en_seen");
      check("restart_second", {idx1, row1, col1}, {12'd1, 7'd3, 7'd6});
      repeat (2) @(negedge clk);
      check("pre_rst_busy", 32'(busy1), 32'd1);
      #2 rst = 1'b1;
      #1 check("async_rst", {en1, valid1, busy1, sd1, terr1, row1, col1, idx1}, 32'd0);
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      check("post_rst_idle", {busy1, en1, valid1}, 3'b000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
